// File: rtl/bsg_manycore_responder_pkg.sv
// rtl/bsg_manycore_responder_pkg.sv - shared types, constants and AMO function for the manycore memory responder
//
// Contents:
//   state_e                    responder FSM states (IDLE/ACCESS/AMO_WR/RESP)
//   e_remote_* op codes        forward packet op field encodings
//   e_return_* type codes      reverse packet type field encodings
//   store_mask_* constants     position of the byte mask inside reg_id for stores
//   amo_alu()                  new-value computation for swap/add/or
package bsg_manycore_responder_pkg;

    localparam int op_width_gp          = 4;
    localparam int reg_id_width_gp      = 5;
    localparam int return_type_width_gp = 2;

    // A store carries its byte-enable mask in the low bits of reg_id.
    localparam int store_mask_lsb_gp   = 0;
    localparam int store_mask_width_gp = 4;

    localparam logic [op_width_gp-1:0] e_remote_load    = 4'd0;
    localparam logic [op_width_gp-1:0] e_remote_store   = 4'd1;
    localparam logic [op_width_gp-1:0] e_remote_amoswap = 4'd2;
    localparam logic [op_width_gp-1:0] e_remote_amoadd  = 4'd3;
    localparam logic [op_width_gp-1:0] e_remote_amoor   = 4'd4;

    localparam logic [return_type_width_gp-1:0] e_return_credit = 2'd0;
    localparam logic [return_type_width_gp-1:0] e_return_int_wb = 2'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        AMO_WR = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Non-AMO op codes fall through to the old value so a stray call cannot corrupt memory.
    function automatic logic [31:0] amo_alu(
        input logic [31:0]            old_data,
        input logic [31:0]            operand,
        input logic [op_width_gp-1:0] op
    );
        logic [31:0] result;
        result = old_data;
        case (op)
            e_remote_amoswap: result = operand;
            e_remote_amoadd:  result = old_data + operand;
            e_remote_amoor:   result = old_data | operand;
            default:          result = old_data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bsg_manycore_responder_amo_alu.sv
// rtl/bsg_manycore_responder_amo_alu.sv - combinational AMO new-value unit
//
// Ports:
//   old_i      in   32  word currently held in memory
//   operand_i  in   32  AMO operand from the request payload
//   op_i       in   4   forward packet op code
//   new_o      out  32  value to write back
module bsg_manycore_responder_amo_alu
    import bsg_manycore_responder_pkg::*;
(
    input  logic [31:0]            old_i,
    input  logic [31:0]            operand_i,
    input  logic [op_width_gp-1:0] op_i,
    output logic [31:0]            new_o
);

    assign new_o = amo_alu(old_i, operand_i, op_i);

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// rtl/bsg_mem_1rw_sync_mask_write_byte.sv - single-port synchronous SRAM with byte write enables
//
// Ports:
//   clk_i         in   1                 clock
//   v_i           in   1                 access enable
//   w_i           in   1                 1 = write, 0 = read
//   addr_i        in   lg(els_p)         word index
//   data_i        in   data_width_p      write data
//   write_mask_i  in   data_width_p/8    byte enables for writes
//   data_o        out  data_width_p      read data, valid the cycle after a read; held until the next read
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter  int els_p               = 1024,
    parameter  int data_width_p        = 32,
    localparam int addr_width_lp       = $clog2(els_p),
    localparam int write_mask_width_lp = data_width_p / 8
) (
    input  logic                           clk_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]        data_o
);

    logic [data_width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int i = 0; i < write_mask_width_lp; i++) begin
                if (write_mask_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
                end
            end
        end
        if (v_i && !w_i) begin
            data_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/bsg_manycore_ready_and_mem_responder.sv
// rtl/bsg_manycore_ready_and_mem_responder.sv - ready/and manycore endpoint responder backed by a local SRAM
//
// Optional feature macro: BSG_MC_RESPONDER_AMO_EN (swap/add/or AMOs via the AMO_WR state).
//
// Ports:
//   clk_i            in   1          core clock
//   reset_n_i        in   1          asynchronous active-low reset
//   my_x_i / my_y_i  in   x/y cord   this endpoint's coordinates
//   fwd_data_i       in   fwd pkt    request packet {addr, op, reg_id, payload, src_y, src_x, y_cord, x_cord}
//   fwd_v_i          in   1          request valid
//   fwd_ready_and_o  out  1          request ready (only in IDLE)
//   rev_data_o       out  rev pkt    return packet {type, data, reg_id, y_cord, x_cord}
//   rev_v_o          out  1          return valid (registered, never depends on rev_ready_and_i)
//   rev_ready_and_i  in   1          return ready
//   err_o            out  1          sticky: a misrouted or unsupported request was seen
//   req_count_o      out  32         number of completed requests
module bsg_manycore_ready_and_mem_responder
    import bsg_manycore_responder_pkg::*;
#(
    parameter  int addr_width_p   = 28,
    parameter  int data_width_p   = 32,
    parameter  int x_cord_width_p = 7,
    parameter  int y_cord_width_p = 7,
    parameter  int els_p          = 1024,
    localparam int fwd_width_lp   = addr_width_p + op_width_gp + reg_id_width_gp + data_width_p
                                    + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int rev_width_lp   = return_type_width_gp + data_width_p + reg_id_width_gp
                                    + x_cord_width_p + y_cord_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic [fwd_width_lp-1:0]   fwd_data_i,
    input  logic                      fwd_v_i,
    output logic                      fwd_ready_and_o,
    output logic [rev_width_lp-1:0]   rev_data_o,
    output logic                      rev_v_o,
    input  logic                      rev_ready_and_i,
    output logic                      err_o,
    output logic [31:0]               req_count_o
);

    localparam int lg_els_lp = $clog2(els_p);

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic [op_width_gp-1:0]     op;
        logic [reg_id_width_gp-1:0] reg_id;
        logic [data_width_p-1:0]    payload;
        logic [y_cord_width_p-1:0]  src_y;
        logic [x_cord_width_p-1:0]  src_x;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } fwd_pkt_s;

    typedef struct packed {
        logic [return_type_width_gp-1:0] pkt_type;
        logic [data_width_p-1:0]         data;
        logic [reg_id_width_gp-1:0]      reg_id;
        logic [y_cord_width_p-1:0]       y_cord;
        logic [x_cord_width_p-1:0]       x_cord;
    } rev_pkt_s;

    // Reset enters asynchronously and leaves two clock edges after reset_n_i rises.
    logic [1:0] rst_sync_r;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_r <= 2'b00;
        else            rst_sync_r <= {rst_sync_r[0], 1'b1};
    end

    assign rst_n = rst_sync_r[1];

    state_e   state_r, state_n;
    fwd_pkt_s pkt_r;
    logic     req_err_r;
    logic     err_r;
    logic [31:0] req_count_r;

    logic is_load, is_store, supported, dest_ok, access_err;
    logic                      sram_v, sram_w;
    logic [data_width_p-1:0]   sram_wdata, sram_rdata;
    logic [data_width_p/8-1:0] sram_mask;
    logic                      unused_addr;

    // Only the low index bits select a word; higher address bits alias.
    assign unused_addr = ^pkt_r.addr[addr_width_p-1:lg_els_lp];

    assign is_load  = (pkt_r.op == e_remote_load);
    assign is_store = (pkt_r.op == e_remote_store);
    assign dest_ok  = (pkt_r.x_cord == my_x_i) && (pkt_r.y_cord == my_y_i);

`ifdef BSG_MC_RESPONDER_AMO_EN
    logic                    is_amo;
    logic [data_width_p-1:0] amo_new;
    logic [data_width_p-1:0] old_r;

    assign is_amo    = (pkt_r.op == e_remote_amoswap) || (pkt_r.op == e_remote_amoadd)
                    || (pkt_r.op == e_remote_amoor);
    assign supported = is_load || is_store || is_amo;

    bsg_manycore_responder_amo_alu amo_alu_u (
        .old_i     (sram_rdata),
        .operand_i (pkt_r.payload),
        .op_i      (pkt_r.op),
        .new_o     (amo_new)
    );
`else
    assign supported = is_load || is_store;
`endif

    assign access_err = !dest_ok || !supported;

    always_comb begin
        state_n    = state_r;
        sram_v     = 1'b0;
        sram_w     = 1'b0;
        sram_wdata = pkt_r.payload;
        sram_mask  = pkt_r.reg_id[store_mask_lsb_gp +: store_mask_width_gp];
        case (state_r)
            IDLE: begin
                if (fwd_v_i) state_n = ACCESS;
            end
            ACCESS: begin
                // A bad request never touches the SRAM; it is answered with a bare credit.
                if (!access_err) begin
                    sram_v = 1'b1;
                    sram_w = is_store;
                end
                state_n = RESP;
`ifdef BSG_MC_RESPONDER_AMO_EN
                if (!access_err && is_amo) state_n = AMO_WR;
`endif
            end
`ifdef BSG_MC_RESPONDER_AMO_EN
            AMO_WR: begin
                // The read issued in ACCESS is on sram_rdata now; write back the combined value.
                sram_v     = 1'b1;
                sram_w     = 1'b1;
                sram_wdata = amo_new;
                sram_mask  = '1;
                state_n    = RESP;
            end
`endif
            RESP: begin
                if (rev_ready_and_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pkt_r       <= '0;
            req_err_r   <= 1'b0;
            err_r       <= 1'b0;
            req_count_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && fwd_v_i) pkt_r <= fwd_pkt_s'(fwd_data_i);
            if (state_r == ACCESS) begin
                req_err_r <= access_err;
                if (access_err) err_r <= 1'b1;
            end
            if (state_r == RESP && rev_ready_and_i) req_count_r <= req_count_r + 32'd1;
        end
    end

`ifdef BSG_MC_RESPONDER_AMO_EN
    // Hold the pre-AMO word; the SRAM output is not guaranteed once the write-back happens.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                 old_r <= '0;
        else if (state_r == AMO_WR) old_r <= sram_rdata;
    end
`endif

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (els_p),
        .data_width_p (data_width_p)
    ) sram_u (
        .clk_i        (clk_i),
        .v_i          (sram_v),
        .w_i          (sram_w),
        .addr_i       (pkt_r.addr[lg_els_lp-1:0]),
        .data_i       (sram_wdata),
        .write_mask_i (sram_mask),
        .data_o       (sram_rdata)
    );

    // Everything below is a function of registered state, so the packet holds steady under backpressure.
    rev_pkt_s rev_pkt;

    always_comb begin
        rev_pkt = '0;
        if (state_r == RESP) begin
            rev_pkt.x_cord   = pkt_r.src_x;
            rev_pkt.y_cord   = pkt_r.src_y;
            rev_pkt.reg_id   = pkt_r.reg_id;
            rev_pkt.pkt_type = e_return_credit;
            if (!req_err_r) begin
                if (is_load) begin
                    rev_pkt.pkt_type = e_return_int_wb;
                    rev_pkt.data     = sram_rdata;
                end
`ifdef BSG_MC_RESPONDER_AMO_EN
                else if (is_amo) begin
                    rev_pkt.pkt_type = e_return_int_wb;
                    rev_pkt.data     = old_r;
                end
`endif
            end
        end
    end

    assign rev_data_o      = rev_pkt;
    assign rev_v_o         = (state_r == RESP);
    assign fwd_ready_and_o = (state_r == IDLE) && rst_n;
    assign err_o           = err_r;
    assign req_count_o     = req_count_r;

endmodule

// File: tb/tb_bsg_manycore_ready_and_mem_responder.sv
// tb/tb_bsg_manycore_ready_and_mem_responder.sv - directed self-checking bench for the manycore memory responder
module tb_bsg_manycore_ready_and_mem_responder;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_BAD   = 4'hF;
    localparam logic [1:0] CREDIT   = 2'd0;
    localparam logic [1:0] INT_WB   = 2'd1;
    localparam logic [6:0] SRC_X    = 7'd1;
    localparam logic [6:0] SRC_Y    = 7'd2;
    localparam logic [6:0] ME_X     = 7'd3;
    localparam logic [6:0] ME_Y     = 7'd5;

    logic        clk;
    logic        reset_n;
    logic [6:0]  my_x, my_y;
    logic [96:0] fwd_data;
    logic        fwd_v, fwd_ready;
    logic [52:0] rev_data;
    logic        rev_v, rev_ready;
    logic        err;
    logic [31:0] req_count;

    int ntests = 0;
    int nfail  = 0;
    int exp_count = 0;

    bsg_manycore_ready_and_mem_responder dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .my_x_i          (my_x),
        .my_y_i          (my_y),
        .fwd_data_i      (fwd_data),
        .fwd_v_i         (fwd_v),
        .fwd_ready_and_o (fwd_ready),
        .rev_data_o      (rev_data),
        .rev_v_o         (rev_v),
        .rev_ready_and_i (rev_ready),
        .err_o           (err),
        .req_count_o     (req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [96:0] mk_fwd(input logic [27:0] addr, input logic [3:0] op,
                                           input logic [4:0] reg_id, input logic [31:0] payload,
                                           input logic [6:0] x, input logic [6:0] y);
        return {addr, op, reg_id, payload, SRC_Y, SRC_X, y, x};
    endfunction

    function automatic logic [52:0] mk_rev(input logic [1:0] t, input logic [31:0] data,
                                           input logic [4:0] reg_id);
        return {t, data, reg_id, SRC_Y, SRC_X};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [96:0] pkt, input string tag);
        int n;
        n = 0;
        fwd_data = pkt;
        fwd_v    = 1'b1;
        while (fwd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 64'(n < 20), 64'd1);
        @(posedge clk);
        #1;
        fwd_v = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [52:0] exp, input int lat, input int hold);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rev_v !== 1'b1 && n < 10);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_data"}, 64'(rev_data), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            rev_ready = 1'b0;
            @(negedge clk);
            check({tag, "_hold_data"}, 64'(rev_data), 64'(exp));
            check({tag, "_hold_v"}, 64'(rev_v), 64'd1);
            check({tag, "_hold_fwd_ready"}, 64'(fwd_ready), 64'd0);
        end
        rev_ready = 1'b1;
        @(posedge clk);
        #1;
        rev_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        check({tag, "_v_drop"}, 64'(rev_v), 64'd0);
        check({tag, "_count"}, 64'(req_count), 64'(exp_count));
    endtask

    initial begin
        reset_n   = 1'b0;
        fwd_v     = 1'b0;
        rev_ready = 1'b0;
        fwd_data  = '0;
        my_x      = ME_X;
        my_y      = ME_Y;
        repeat (3) @(negedge clk);
        check("rst_rev_v", 64'(rev_v), 64'd0);
        check("rst_fwd_ready", 64'(fwd_ready), 64'd0);
        check("rst_rev_data", 64'(rev_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_count", 64'(req_count), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 64'(fwd_ready), 64'd1);

        // Full-word store then load.
        accept(mk_fwd(28'h10, OP_STORE, 5'h0F, 32'hDEADBEEF, ME_X, ME_Y), "st1");
        expect_resp("st1", mk_rev(CREDIT, 32'h0, 5'h0F), 2, 0);
        accept(mk_fwd(28'h10, OP_LOAD, 5'h07, 32'h0, ME_X, ME_Y), "ld1");
        expect_resp("ld1", mk_rev(INT_WB, 32'hDEADBEEF, 5'h07), 2, 0);

        // Partial store, mask 0x3 (reg_id bit 4 set to show it is not part of the mask).
        accept(mk_fwd(28'h10, OP_STORE, 5'h13, 32'h11223344, ME_X, ME_Y), "st2");
        expect_resp("st2", mk_rev(CREDIT, 32'h0, 5'h13), 2, 0);
        accept(mk_fwd(28'h10, OP_LOAD, 5'h01, 32'h0, ME_X, ME_Y), "ld2");
        expect_resp("ld2", mk_rev(INT_WB, 32'hDEAD3344, 5'h01), 2, 0);

        // Address bit 10 lies above the 1024-word index and must alias onto 0x10.
        accept(mk_fwd(28'h410, OP_LOAD, 5'h02, 32'h0, ME_X, ME_Y), "alias");
        expect_resp("alias", mk_rev(INT_WB, 32'hDEAD3344, 5'h02), 2, 0);

        // Backpressure for 10 cycles in RESP.
        accept(mk_fwd(28'h10, OP_LOAD, 5'h1E, 32'h0, ME_X, ME_Y), "bp");
        expect_resp("bp", mk_rev(INT_WB, 32'hDEAD3344, 5'h1E), 2, 10);

        // AMO add 5 onto 7.
        accept(mk_fwd(28'h20, OP_STORE, 5'h0F, 32'h7, ME_X, ME_Y), "st7");
        expect_resp("st7", mk_rev(CREDIT, 32'h0, 5'h0F), 2, 0);
        accept(mk_fwd(28'h20, OP_ADD, 5'h03, 32'h5, ME_X, ME_Y), "amo");
`ifdef BSG_MC_RESPONDER_AMO_EN
        expect_resp("amo", mk_rev(INT_WB, 32'h7, 5'h03), 3, 0);
        check("amo_err", 64'(err), 64'd0);
        accept(mk_fwd(28'h20, OP_LOAD, 5'h04, 32'h0, ME_X, ME_Y), "amo_ld");
        expect_resp("amo_ld", mk_rev(INT_WB, 32'hC, 5'h04), 2, 0);
`else
        expect_resp("amo", mk_rev(CREDIT, 32'h0, 5'h03), 2, 0);
        check("amo_err", 64'(err), 64'd1);
        accept(mk_fwd(28'h20, OP_LOAD, 5'h04, 32'h0, ME_X, ME_Y), "amo_ld");
        expect_resp("amo_ld", mk_rev(INT_WB, 32'h7, 5'h04), 2, 0);
`endif

        // Misrouted store: x_cord one past ours.
        accept(mk_fwd(28'h10, OP_STORE, 5'h0F, 32'h55555555, ME_X + 7'd1, ME_Y), "xerr");
        expect_resp("xerr", mk_rev(CREDIT, 32'h0, 5'h0F), 2, 0);
        check("xerr_err", 64'(err), 64'd1);
        accept(mk_fwd(28'h10, OP_LOAD, 5'h05, 32'h0, ME_X, ME_Y), "xerr_ld");
        expect_resp("xerr_ld", mk_rev(INT_WB, 32'hDEAD3344, 5'h05), 2, 0);
        check("err_sticky", 64'(err), 64'd1);

        // Unsupported op code.
        accept(mk_fwd(28'h10, OP_BAD, 5'h06, 32'h12345678, ME_X, ME_Y), "badop");
        expect_resp("badop", mk_rev(CREDIT, 32'h0, 5'h06), 2, 0);

        // Reset while the request is in ACCESS.
        accept(mk_fwd(28'h10, OP_LOAD, 5'h08, 32'h0, ME_X, ME_Y), "rst_mid");
        reset_n = 1'b0;
        #1;
        check("mid_rst_rev_v", 64'(rev_v), 64'd0);
        check("mid_rst_fwd_ready", 64'(fwd_ready), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_count", 64'(req_count), 64'd0);
        check("mid_rst_rev_data", 64'(rev_data), 64'd0);
        exp_count = 0;
        repeat (3) @(negedge clk);
        check("mid_rst_hold_rev_v", 64'(rev_v), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_rev_v", 64'(rev_v), 64'd0);
        check("post_rst_ready", 64'(fwd_ready), 64'd1);
        check("post_rst_count", 64'(req_count), 64'd0);

        accept(mk_fwd(28'h30, OP_STORE, 5'h0F, 32'hCAFEF00D, ME_X, ME_Y), "post_st");
        expect_resp("post_st", mk_rev(CREDIT, 32'h0, 5'h0F), 2, 0);
        accept(mk_fwd(28'h30, OP_LOAD, 5'h09, 32'h0, ME_X, ME_Y), "post_ld");
        expect_resp("post_ld", mk_rev(INT_WB, 32'hCAFEF00D, 5'h09), 2, 0);
        check("post_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
